neuron_state_sequencer: RTL
===========================

Name: neuron_state_sequencer

Overview:
- Time-multiplexed state store and scheduler for a population of Izhikevich neurons.
- Shares one combinational integrator stage across all neurons. Per timestep it presents each neuron's (I, v_old, w_old) to the integrator in index order and writes back (v_new, w_new).
- Collects per-neuron fire bits into a spike vector for the downstream synapse/router stage.
- Fixed-point Q16.16 throughout: 1.0 = 32'h0001_0000.

Parameters:
- N, 32, datapath width of v, w, I (Q(N/2).(N/2)).
- NUM_NEURONS, 8, neurons in the population (>=2).
- IDX_W, 3, index width; must satisfy 2^IDX_W >= NUM_NEURONS.
- V_INIT, 32'hFFBF_0000, reset/init membrane value (-65 mV).
- W_INIT, 32'hFFF3_0000, reset/init recovery value (-13).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- step_start  in  1  single-cycle pulse requesting one integration timestep (dt = 1/8 ms).
- init  in  1  single-cycle pulse: reload all neurons with V_INIT/W_INIT.
- cur_idx  out  IDX_W  index of the neuron whose input current is requested.
- cur_I  in  N  input current for cur_idx; combinational, sampled the same cycle.
- int_I  out  N  to integrator I; equals cur_I while busy, else 0.
- int_v_old  out  N  to integrator v_old; v[cur_idx].
- int_w_old  out  N  to integrator w_old; w[cur_idx].
- int_v_new  in  N  from integrator, combinational same cycle.
- int_w_new  in  N  from integrator, combinational same cycle.
- int_fire  in  1  from integrator, combinational same cycle.
- busy  out  1  high while a timestep is in progress.
- step_done  out  1  single-cycle pulse when the timestep completes.
- spike_vec  out  NUM_NEURONS  fire bits of the last completed step; bit k = neuron k.
- spike_count  out  IDX_W+1  popcount of spike_vec.
- step_count  out  N  number of completed timesteps, wraps modulo 2^N.
- overrun  out  1  sticky; set when step_start or init arrives while busy.
- probe_idx  in  IDX_W  debug read index.
- probe_v  out  N  v[probe_idx], combinational.
- probe_w  out  N  w[probe_idx], combinational.

Behaviour:
- Reset (rst_n low, async):
  - v[k]=V_INIT and w[k]=W_INIT for all k.
  - FSM=IDLE; cur_idx=0; busy=0; step_done=0; spike_vec=0; spike_count=0; step_count=0; overrun=0; internal spike accumulator=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - busy=0.
  - init=1: all v/w reloaded next edge; spike_vec, counts and overrun are unchanged.
  - step_start=1: go to RUN, cur_idx=0, accumulator cleared.
  - init and step_start in the same cycle: init wins and step_start is dropped (not flagged).
- RUN (busy=1), one neuron per cycle:
  - At each edge: v[cur_idx]<=int_v_new; w[cur_idx]<=int_w_new; acc[cur_idx]<=int_fire.
  - If cur_idx==NUM_NEURONS-1: go to DONE, cur_idx<=0. Otherwise cur_idx<=cur_idx+1.
- DONE (busy=1, one cycle):
  - step_done=1 for that cycle.
  - spike_vec<=acc and spike_count<=popcount(acc) at the exit edge.
  - step_count<=step_count+1 (wraps at 2^N-1 -> 0).
  - Next state IDLE.
- Latency:
  - step_start sampled at edge t -> RUN cycles t+1..t+NUM_NEURONS -> step_done high in cycle t+NUM_NEURONS+1.
  - spike_vec updates at the end of that cycle.
  - Minimum step_start spacing is NUM_NEURONS+2 cycles.
- spike_vec/spike_count hold their value until the next DONE. Neurons that did not fire in a step produce a 0 bit.
- step_start or init while busy (RUN or DONE):
  - Ignored; no state change to v/w schedule.
  - overrun<=1 (sticky until reset).
- int_* outputs:
  - Driven from the registered cur_idx every cycle.
  - int_I is forced to 0 when not busy, so the integrator never sees stale current.
- No arithmetic in this block; int_v_new/int_w_new are stored verbatim (reset-on-fire is done by the integrator).
- Reset asserted mid-RUN: everything returns to reset values immediately; the partial step is discarded and no step_done is produced.
- probe_v/probe_w reflect written state the cycle after the write edge.

Test Plan:
- Reset release, then probe_idx 0..7 -> probe_v=32'hFFBF_0000 and probe_w=32'hFFF3_0000 for every index; busy=0; step_count=0.
- Stub integrator (v_new=v_old+32'h0001_0000, w_new=w_old, fire=0), cur_I=0, one step_start:
  - busy for 9 cycles; step_done exactly once, 9 cycles after the start edge.
  - cur_idx sequence 0..7.
  - All probe_v=32'hFFC0_0000; step_count=1; spike_vec=0.
- Stub fire=(cur_idx odd), one step -> spike_vec=8'hAA, spike_count=4; values hold through 20 idle cycles.
- step_start re-pulsed at cycle 3 of RUN -> ignored; step_done only once; overrun=1, and it stays 1 after the next clean step.
- Real integrator, cur_I=32'h000A_0000 (10), 200 steps from init -> at least one spike; on a firing step that neuron's probe_v=32'hFFBF_0000.
- Assert rst_n low at cycle 4 of RUN -> no step_done; all state at reset values; step_count=0.
- init pulse after 3 steps -> all v/w at init values; step_count stays 3.

Source files
------------

// File: rtl/neuron_state_sequencer.sv
// Time-multiplexed v/w state store and scheduler for a population of Izhikevich neurons.
// One shared combinational integrator is walked over every neuron once per timestep.
module neuron_state_sequencer #(
    parameter int          N           = 32,
    parameter int          NUM_NEURONS = 8,
    parameter int          IDX_W       = 3,
    parameter logic [N-1:0] V_INIT     = 32'hFFBF_0000,
    parameter logic [N-1:0] W_INIT     = 32'hFFF3_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   step_start,
    input  logic                   init,
    output logic [IDX_W-1:0]       cur_idx,
    input  logic [N-1:0]           cur_I,
    output logic [N-1:0]           int_I,
    output logic [N-1:0]           int_v_old,
    output logic [N-1:0]           int_w_old,
    input  logic [N-1:0]           int_v_new,
    input  logic [N-1:0]           int_w_new,
    input  logic                   int_fire,
    output logic                   busy,
    output logic                   step_done,
    output logic [NUM_NEURONS-1:0] spike_vec,
    output logic [IDX_W:0]         spike_count,
    output logic [N-1:0]           step_count,
    output logic                   overrun,
    input  logic [IDX_W-1:0]       probe_idx,
    output logic [N-1:0]           probe_v,
    output logic [N-1:0]           probe_w,
    output logic [1:0]             state_dbg
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    logic [1:0]             state;
    logic [N-1:0]           v_mem [NUM_NEURONS];
    logic [N-1:0]           w_mem [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] acc;
    logic [IDX_W:0]         acc_pop;

    always_comb begin
        acc_pop = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            acc_pop = acc_pop + (IDX_W+1)'(acc[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cur_idx     <= '0;
            acc         <= '0;
            spike_vec   <= '0;
            spike_count <= '0;
            step_count  <= '0;
            overrun     <= 1'b0;
            for (int k = 0; k < NUM_NEURONS; k++) begin
                v_mem[k] <= V_INIT;
                w_mem[k] <= W_INIT;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    // init has priority; a simultaneous step_start is silently dropped
                    if (init) begin
                        for (int k = 0; k < NUM_NEURONS; k++) begin
                            v_mem[k] <= V_INIT;
                            w_mem[k] <= W_INIT;
                        end
                    end else if (step_start) begin
                        state   <= S_RUN;
                        cur_idx <= '0;
                        acc     <= '0;
                    end
                end
                S_RUN: begin
                    if (step_start || init) overrun <= 1'b1;
                    v_mem[cur_idx] <= int_v_new;
                    w_mem[cur_idx] <= int_w_new;
                    acc[cur_idx]   <= int_fire;
                    if (cur_idx == LAST_IDX) begin
                        state   <= S_DONE;
                        cur_idx <= '0;
                    end else begin
                        cur_idx <= cur_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (step_start || init) overrun <= 1'b1;
                    spike_vec   <= acc;
                    spike_count <= acc_pop;
                    step_count  <= step_count + N'(1);
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign step_done = (state == S_DONE);
    // Zero current outside a step so the integrator never sees a stale value.
    assign int_I     = busy ? cur_I : '0;
    assign int_v_old = v_mem[cur_idx];
    assign int_w_old = w_mem[cur_idx];
    assign probe_v   = v_mem[probe_idx];
    assign probe_w   = w_mem[probe_idx];
    assign state_dbg = state;

endmodule
